// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encodings
// and the default reset/trap vector addresses.
package pc_gen_pkg;

  // Next-PC select encodings driven by the decoder
  typedef enum logic [2:0] {
    PCSRC_NORMAL = 3'b000,
    PCSRC_BRANCH = 3'b001,
    PCSRC_JUMP   = 3'b010,
    PCSRC_A      = 3'b011,
    PCSRC_ILLOP  = 3'b100,
    PCSRC_XADR   = 3'b101
  } pcsrc_e;

  // Default vectors; the supervisor bit (MSB) is set in all of them
  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

endpackage

// File: rtl/pc_gen_if.sv
// Control/datapath side of the PC unit. The master drives select, targets,
// stall and irq; the slave (pc_gen) returns the PC values and status.
interface pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic [2:0]        PCSrc;
  logic [ADDR_W-1:0] ConBA;
  logic              ALUOut0;
  logic [25:0]       JT;
  logic [ADDR_W-1:0] DataBusA;
  logic              irq;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] PCPlus4;
  logic [ADDR_W-1:0] NewPC;
  logic [ADDR_W-1:0] EPC;
  logic              irq_taken;
  logic              in_kernel;

  modport master (
    output stall, PCSrc, ConBA, ALUOut0, JT, DataBusA, irq,
    input  PC, PCPlus4, NewPC, EPC, irq_taken, in_kernel
  );

  modport slave (
    input  stall, PCSrc, ConBA, ALUOut0, JT, DataBusA, irq,
    output PC, PCPlus4, NewPC, EPC, irq_taken, in_kernel
  );
endinterface

// File: rtl/pc_gen_pc_next_mux.sv
// Combinational next-PC selection with the supervisor-bit rule applied.
// User code can never set the MSB: only the trap vectors can enter kernel mode.
module pc_next_mux
  import pc_gen_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC,
  parameter logic [31:0] XADR_VEC  = DEF_XADR_VEC
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_pc_plus4,
  input  logic [2:0]        i_pcsrc,
  input  logic [ADDR_W-1:0] i_conba,
  input  logic              i_aluout0,
  input  logic [25:0]       i_jt,
  input  logic [ADDR_W-1:0] i_databusa,
  output logic [ADDR_W-1:0] o_new_pc
);
  localparam int                MSB     = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] ILLOP_V = ADDR_W'(ILLOP_VEC);
  localparam logic [ADDR_W-1:0] XADR_V  = ADDR_W'(XADR_VEC);

  logic [ADDR_W-1:0] w_base;
  logic              w_msb;
  logic [ADDR_W-1:0] w_splice;

  // J-type target keeps the segment bits of the current PC, including the mode bit
  assign w_splice = {i_pc[MSB:28], i_jt, 2'b00};

  // Base target select plus the mode bit each path is allowed to produce
  always_comb begin
    w_base = i_pc_plus4;
    w_msb  = i_pc[MSB];
    case (i_pcsrc)
      PCSRC_NORMAL: begin
        // Sequential flow stays in the current mode even across a wrap
        w_base = i_pc_plus4;
        w_msb  = i_pc[MSB];
      end
      PCSRC_BRANCH: begin
        w_base = i_aluout0 ? i_conba : i_pc_plus4;
        w_msb  = i_pc[MSB];
      end
      PCSRC_JUMP: begin
        w_base = w_splice;
        w_msb  = i_pc[MSB];
      end
      PCSRC_A: begin
        // jr may drop to user mode but can never raise privilege
        w_base = i_databusa;
        w_msb  = i_databusa[MSB] & i_pc[MSB];
      end
      PCSRC_ILLOP: begin
        w_base = ILLOP_V;
        w_msb  = ILLOP_V[MSB];
      end
      default: begin
        // XADR and both undefined encodings trap to the exception vector
        w_base = XADR_V;
        w_msb  = XADR_V[MSB];
      end
    endcase
  end

  assign o_new_pc = {w_msb, w_base[MSB-1:0]};

endmodule

// File: rtl/pc_gen.sv
// Program-counter unit: registered PC with stall hold, level interrupt
// latch, interrupt take logic and EPC capture.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC,
  parameter logic [31:0] XADR_VEC  = DEF_XADR_VEC
) (
  input logic          clk,
  input logic          reset,
  pc_gen_if.slave      bus
);
  localparam int                MSB     = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] ILLOP_V = ADDR_W'(ILLOP_VEC);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_epc;
  logic              r_irq_pend;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_mux_pc;
  logic [ADDR_W-1:0] w_new_pc;
  logic              w_take;

  assign w_pc_plus4 = r_pc + ADDR_W'(32'd4);

  pc_next_mux #(
    .ADDR_W    (ADDR_W),
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_next_mux (
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .i_pcsrc    (bus.PCSrc),
    .i_conba    (bus.ConBA),
    .i_aluout0  (bus.ALUOut0),
    .i_jt       (bus.JT),
    .i_databusa (bus.DataBusA),
    .o_new_pc   (w_mux_pc)
  );

  // Interrupts are only taken from user mode on an advancing cycle, and
  // override whatever the decoder selected (including a same-cycle XADR).
  assign w_take   = r_irq_pend & ~r_pc[MSB] & ~bus.stall & ~reset;
  assign w_new_pc = w_take ? ILLOP_V : w_mux_pc;

  // PC, EPC and pending-interrupt state; a still-high irq re-arms the latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_V;
      r_epc      <= '0;
      r_irq_pend <= 1'b0;
    end else begin
      r_irq_pend <= bus.irq | (r_irq_pend & ~w_take);
      if (!bus.stall) begin
        r_pc <= w_new_pc;
        if (w_take) begin
          r_epc <= r_pc;
        end else begin
          r_epc <= r_epc;
        end
      end else begin
        r_pc  <= r_pc;
        r_epc <= r_epc;
      end
    end
  end

  assign bus.PC        = r_pc;
  assign bus.PCPlus4   = w_pc_plus4;
  assign bus.NewPC     = w_new_pc;
  assign bus.EPC       = r_epc;
  assign bus.irq_taken = w_take;
  assign bus.in_kernel = r_pc[MSB];

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: expected PCs are queued when a cycle is
// driven and popped/compared once the edge has been taken.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_pc;

  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(AW)) bus ();

  pc_gen #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Push the PC expected after the coming edge, then take the edge
  task automatic tick(input logic [AW-1:0] exp_next);
    exp_q.push_back(exp_next);
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input logic [2:0] src, input logic [AW-1:0] a);
    bus.PCSrc    = src;
    bus.DataBusA = a;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.stall = 1'b0; bus.irq = 1'b0; bus.PCSrc = 3'b000;
    bus.ConBA = '0; bus.ALUOut0 = 1'b0; bus.JT = '0; bus.DataBusA = '0;
    tick(32'h8000_0000);
    tick(32'h8000_0000);
    reset = 1'b0;
    void'(exp_q.pop_front());
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.PC, exp_pc); end
    checks++;
    if (bus.EPC !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want 0", bus.EPC); end
    checks++;
    if (bus.in_kernel !== 1'b1 || bus.irq_taken !== 1'b0) begin
      errors++; $display("FAIL reset_status: in_kernel=%b irq_taken=%b want 1 0", bus.in_kernel, bus.irq_taken);
    end
    checks++;
    if (bus.PCPlus4 !== 32'h8000_0004) begin errors++; $display("FAIL reset_plus4: got %h want 80000004", bus.PCPlus4); end
  endtask

  task automatic test_sequential();
    logic [AW-1:0] model_pc = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      set_src(3'b000, '0);
      model_pc = model_pc + 32'd4;
      tick(model_pc);
      exp_pc = exp_q.pop_front(); checks++;
      if (bus.PC !== exp_pc) begin errors++; $display("FAIL seq_%0d: got %h want %h", i, bus.PC, exp_pc); end
    end
  endtask

  task automatic test_jump_jr();
    set_src(3'b011, 32'h0000_0100); tick(32'h0000_0100);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc) begin errors++; $display("FAIL jr_to_user: got %h want %h", bus.PC, exp_pc); end
    bus.JT = 26'h000_0040; set_src(3'b010, '0);
    checks++;
    if (bus.NewPC !== 32'h0000_0100) begin errors++; $display("FAIL jump_newpc: got %h want 00000100", bus.NewPC); end
    tick(32'h0000_0100);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc) begin errors++; $display("FAIL jump_splice: got %h want %h", bus.PC, exp_pc); end
    set_src(3'b011, 32'h8000_0000); tick(32'h0000_0000);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc || bus.in_kernel !== 1'b0) begin
      errors++; $display("FAIL jr_kernel_blocked: got %h want %h", bus.PC, exp_pc);
    end
    set_src(3'b100, '0); tick(32'h8000_0004); void'(exp_q.pop_front());
    checks++;
    if (bus.EPC !== 32'h0) begin errors++; $display("FAIL illop_no_epc: got %h want 0", bus.EPC); end
    for (int i = 0; i < 3; i++) begin
      set_src(3'b000, '0); tick(32'h8000_0008 + 32'(i) * 32'd4); void'(exp_q.pop_front());
    end
    checks++;
    if (bus.PC !== 32'h8000_0010) begin errors++; $display("FAIL kernel_walk: got %h want 80000010", bus.PC); end
    bus.JT = 26'h3FF_FFFF; set_src(3'b010, '0); tick(32'h8FFF_FFFC);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc) begin errors++; $display("FAIL jump_kernel_splice: got %h want %h", bus.PC, exp_pc); end
    set_src(3'b011, 32'h0000_0200); tick(32'h0000_0200);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc) begin errors++; $display("FAIL jr_kernel_exit: got %h want %h", bus.PC, exp_pc); end
  endtask

  task automatic test_branch();
    set_src(3'b011, 32'h0000_0020); tick(32'h0000_0020); void'(exp_q.pop_front());
    bus.ConBA = 32'h0000_0040; bus.ALUOut0 = 1'b1; set_src(3'b001, '0); tick(32'h0000_0040);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc) begin errors++; $display("FAIL branch_taken: got %h want %h", bus.PC, exp_pc); end
    set_src(3'b011, 32'h0000_0020); tick(32'h0000_0020); void'(exp_q.pop_front());
    bus.ALUOut0 = 1'b0; set_src(3'b001, '0); tick(32'h0000_0024);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc) begin errors++; $display("FAIL branch_not_taken: got %h want %h", bus.PC, exp_pc); end
    bus.ConBA = 32'h8000_0100; bus.ALUOut0 = 1'b1; set_src(3'b001, '0); tick(32'h0000_0100);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc) begin errors++; $display("FAIL branch_msb_forced: got %h want %h", bus.PC, exp_pc); end
    bus.ALUOut0 = 1'b0;
  endtask

  task automatic test_stall_irq();
    set_src(3'b011, 32'h0000_0030); tick(32'h0000_0030); void'(exp_q.pop_front());
    bus.stall = 1'b1; bus.irq = 1'b1; set_src(3'b000, '0); tick(32'h0000_0030);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc) begin errors++; $display("FAIL stall_hold_1: got %h want %h", bus.PC, exp_pc); end
    bus.irq = 1'b0; #1;
    checks++;
    if (bus.irq_taken !== 1'b0 || bus.NewPC !== 32'h0000_0034) begin
      errors++; $display("FAIL stall_no_take: irq_taken=%b NewPC=%h want 0 00000034", bus.irq_taken, bus.NewPC);
    end
    tick(32'h0000_0030);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc) begin errors++; $display("FAIL stall_hold_2: got %h want %h", bus.PC, exp_pc); end
    bus.stall = 1'b0; #1;
    checks++;
    if (bus.irq_taken !== 1'b1 || bus.NewPC !== 32'h8000_0004) begin
      errors++; $display("FAIL irq_take: irq_taken=%b NewPC=%h want 1 80000004", bus.irq_taken, bus.NewPC);
    end
    tick(32'h8000_0004);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc || bus.EPC !== 32'h0000_0030) begin
      errors++; $display("FAIL irq_entry: PC=%h EPC=%h want %h 00000030", bus.PC, bus.EPC, exp_pc);
    end
  endtask

  task automatic test_kernel_irq();
    bus.irq = 1'b1; set_src(3'b000, '0);
    checks++;
    if (bus.irq_taken !== 1'b0) begin errors++; $display("FAIL kernel_no_take: got %b want 0", bus.irq_taken); end
    tick(32'h8000_0008); void'(exp_q.pop_front());
    bus.irq = 1'b0; set_src(3'b100, '0); tick(32'h8000_0004);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc || bus.EPC !== 32'h0000_0030) begin
      errors++; $display("FAIL sw_illop: PC=%h EPC=%h want %h 00000030", bus.PC, bus.EPC, exp_pc);
    end
    set_src(3'b011, 32'h0000_0038); tick(32'h0000_0038); void'(exp_q.pop_front());
    set_src(3'b101, '0);
    checks++;
    if (bus.irq_taken !== 1'b1 || bus.NewPC !== 32'h8000_0004) begin
      errors++; $display("FAIL irq_over_xadr: irq_taken=%b NewPC=%h want 1 80000004", bus.irq_taken, bus.NewPC);
    end
    tick(32'h8000_0004);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc || bus.EPC !== 32'h0000_0038) begin
      errors++; $display("FAIL deferred_entry: PC=%h EPC=%h want %h 00000038", bus.PC, bus.EPC, exp_pc);
    end
    set_src(3'b011, 32'h0000_0050); tick(32'h0000_0050); void'(exp_q.pop_front());
    set_src(3'b000, '0); tick(32'h0000_0054);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc) begin errors++; $display("FAIL pend_cleared: got %h want %h", bus.PC, exp_pc); end
  endtask

  task automatic test_undef_reset();
    set_src(3'b111, '0); tick(32'h8000_0008);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc) begin errors++; $display("FAIL undef_111: got %h want %h", bus.PC, exp_pc); end
    set_src(3'b011, 32'h0000_0060); tick(32'h0000_0060); void'(exp_q.pop_front());
    bus.stall = 1'b1; bus.irq = 1'b1; set_src(3'b000, '0); tick(32'h0000_0060); void'(exp_q.pop_front());
    bus.irq = 1'b0; reset = 1'b1; #1; tick(32'h8000_0000);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc || bus.EPC !== 32'h0) begin
      errors++; $display("FAIL reset_in_stall: PC=%h EPC=%h want %h 0", bus.PC, bus.EPC, exp_pc);
    end
    reset = 1'b0; bus.stall = 1'b0;
    set_src(3'b011, 32'h0000_0040); tick(32'h0000_0040); void'(exp_q.pop_front());
    set_src(3'b000, '0);
    checks++;
    if (bus.irq_taken !== 1'b0) begin errors++; $display("FAIL reset_clears_pend: irq_taken=%b want 0", bus.irq_taken); end
    tick(32'h0000_0044);
    exp_pc = exp_q.pop_front(); checks++;
    if (bus.PC !== exp_pc) begin errors++; $display("FAIL after_reset_seq: got %h want %h", bus.PC, exp_pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump_jr();
    test_branch();
    test_stall_irq();
    test_kernel_irq();
    test_undef_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
